// File: rtl/chdr_pkt_deframer.sv
// CHDR deframer: strips header, timestamp and metadata words, forwards the payload
// with tkeep, and holds the header/timestamp as sideband for the whole packet.
module chdr_pkt_deframer #(
    parameter int CHDR_W   = 64,
    parameter int MTU_LOG2 = 10
) (
    input  logic                chdr_clk,
    input  logic                chdr_rst,
    input  logic [CHDR_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [CHDR_W-1:0]   m_axis_tdata,
    output logic [CHDR_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [63:0]         m_header,
    output logic [63:0]         m_timestamp,
    output logic                m_has_time,
    output logic                empty_pkt,
    output logic                err_len
);

    localparam int BPW      = CHDR_W / 8;
    localparam int BPW_LOG2 = $clog2(BPW);
    localparam int CNT_W    = MTU_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_HDR   = 2'd0;
    localparam logic [1:0] ST_TS    = 2'd1;
    localparam logic [1:0] ST_MDATA = 2'd2;
    localparam logic [1:0] ST_PYLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [63:0]      header_q, header_d;
    logic [63:0]      ts_q, ts_d;
    logic             has_time_q, has_time_d;
    logic [4:0]       mdata_cnt_q, mdata_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;

    logic             s_hs;
    logic [15:0]      cur_len;
    logic [4:0]       cur_nmd;
    logic             cur_has_time;
    logic             ts_word;
    logic [16:0]      exp_beats;
    logic [16:0]      act_beats;
    logic [16:0]      ovh_bytes;
    logic             len_has_pyld;
    logic [BPW_LOG2-1:0] len_rem;
    logic [BPW-1:0]   keep_last;
    logic [63:0]      hdr_ts;

    // Wide buses carry the timestamp alongside the header in the same beat.
    generate
        if (CHDR_W > 64) begin : g_wide_ts
            assign hdr_ts = s_axis_tdata[127:64];
        end else begin : g_narrow_ts
            assign hdr_ts = '0;
        end
    endgenerate

    // Header fields come straight off the bus during the header beat, else from the capture.
    assign cur_len      = (state_q == ST_HDR) ? s_axis_tdata[31:16] : header_q[31:16];
    assign cur_nmd      = (state_q == ST_HDR) ? s_axis_tdata[52:48] : header_q[52:48];
    assign cur_has_time = (state_q == ST_HDR) ? (s_axis_tdata[55:53] == 3'h7) : has_time_q;
    assign ts_word      = (CHDR_W == 64) && cur_has_time;

    assign exp_beats    = ({1'b0, cur_len} + 17'(BPW - 1)) >> BPW_LOG2;
    assign act_beats    = 17'(beat_cnt_q) + 17'd1;
    assign ovh_bytes    = (17'd1 + 17'(ts_word) + 17'(cur_nmd)) << BPW_LOG2;
    assign len_has_pyld = {1'b0, cur_len} > ovh_bytes;
    assign len_rem      = cur_len[BPW_LOG2-1:0];

    always_comb begin
        keep_last = '0;
        for (int i = 0; i < BPW; i++) begin
            keep_last[i] = (len_rem == '0) || (i < int'(len_rem));
        end
    end

    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign s_axis_tready = (state_q == ST_PYLD) ? m_axis_tready : 1'b1;
    assign m_axis_tvalid = (state_q == ST_PYLD) && s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tkeep  = s_axis_tlast ? keep_last : '1;

    assign m_header    = header_q;
    assign m_timestamp = ts_q;
    assign m_has_time  = has_time_q;
    assign empty_pkt   = empty_q;
    assign err_len     = err_q;

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        ts_d        = ts_q;
        has_time_d  = has_time_q;
        mdata_cnt_d = mdata_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        empty_d     = 1'b0;
        err_d       = 1'b0;
        if (s_hs) begin
            beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_ONE;
            case (state_q)
                ST_HDR: begin
                    header_d    = s_axis_tdata[63:0];
                    has_time_d  = cur_has_time;
                    ts_d        = cur_has_time ? hdr_ts : 64'd0;
                    mdata_cnt_d = cur_nmd;
                    beat_cnt_d  = CNT_ONE;
                    if (s_axis_tlast) begin
                        empty_d = 1'b1;
                        err_d   = len_has_pyld;
                    end else if (ts_word) begin
                        state_d = ST_TS;
                    end else if (cur_nmd != 5'd0) begin
                        state_d = ST_MDATA;
                    end else begin
                        state_d = ST_PYLD;
                    end
                end
                ST_TS: begin
                    ts_d = s_axis_tdata[63:0];
                    if (s_axis_tlast) begin
                        state_d = ST_HDR;
                        empty_d = 1'b1;
                        err_d   = len_has_pyld;
                    end else if (mdata_cnt_q != 5'd0) begin
                        state_d = ST_MDATA;
                    end else begin
                        state_d = ST_PYLD;
                    end
                end
                ST_MDATA: begin
                    mdata_cnt_d = mdata_cnt_q - 5'd1;
                    if (s_axis_tlast) begin
                        state_d = ST_HDR;
                        empty_d = 1'b1;
                        err_d   = len_has_pyld;
                    end else if (mdata_cnt_q <= 5'd1) begin
                        state_d = ST_PYLD;
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        state_d = ST_HDR;
                        err_d   = (act_beats != exp_beats);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge chdr_clk) begin
        if (chdr_rst) begin
            state_q     <= ST_HDR;
            header_q    <= '0;
            ts_q        <= '0;
            has_time_q  <= 1'b0;
            mdata_cnt_q <= '0;
            beat_cnt_q  <= '0;
            empty_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            ts_q        <= ts_d;
            has_time_q  <= has_time_d;
            mdata_cnt_q <= mdata_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            empty_q     <= empty_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_chdr_pkt_deframer.sv
// Directed bench for chdr_pkt_deframer: a 64-bit and a 256-bit instance driven
// by scenario tasks, with a negedge monitor recording every accepted payload beat.
module tb_chdr_pkt_deframer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0]  s_tdata64;
    logic         s_tlast64, s_tvalid64, s_tready64;
    logic [63:0]  m_tdata64;
    logic [7:0]   m_tkeep64;
    logic         m_tlast64, m_tvalid64, m_tready64;
    logic [63:0]  hdr64, ts64;
    logic         ht64, empty64, err64;

    logic [255:0] s_tdata256;
    logic         s_tlast256, s_tvalid256, s_tready256;
    logic [255:0] m_tdata256;
    logic [31:0]  m_tkeep256;
    logic         m_tlast256, m_tvalid256, m_tready256;
    logic [63:0]  hdr256, ts256;
    logic         ht256, empty256, err256;

    int tests_run = 0;
    int fail_cnt  = 0;

    chdr_pkt_deframer #(.CHDR_W(64), .MTU_LOG2(10)) dut64 (
        .chdr_clk(clk), .chdr_rst(rst),
        .s_axis_tdata(s_tdata64), .s_axis_tlast(s_tlast64),
        .s_axis_tvalid(s_tvalid64), .s_axis_tready(s_tready64),
        .m_axis_tdata(m_tdata64), .m_axis_tkeep(m_tkeep64),
        .m_axis_tlast(m_tlast64), .m_axis_tvalid(m_tvalid64),
        .m_axis_tready(m_tready64),
        .m_header(hdr64), .m_timestamp(ts64), .m_has_time(ht64),
        .empty_pkt(empty64), .err_len(err64)
    );

    chdr_pkt_deframer #(.CHDR_W(256), .MTU_LOG2(10)) dut256 (
        .chdr_clk(clk), .chdr_rst(rst),
        .s_axis_tdata(s_tdata256), .s_axis_tlast(s_tlast256),
        .s_axis_tvalid(s_tvalid256), .s_axis_tready(s_tready256),
        .m_axis_tdata(m_tdata256), .m_axis_tkeep(m_tkeep256),
        .m_axis_tlast(m_tlast256), .m_axis_tvalid(m_tvalid256),
        .m_axis_tready(m_tready256),
        .m_header(hdr256), .m_timestamp(ts256), .m_has_time(ht256),
        .empty_pkt(empty256), .err_len(err256)
    );

    // Monitor: records each payload beat that completes at the following posedge.
    logic [63:0]  q64_data[$];
    logic [7:0]   q64_keep[$];
    logic         q64_last[$];
    logic [63:0]  q64_hdr[$];
    logic [63:0]  q64_ts[$];
    logic         q64_ht[$];
    logic [255:0] q256_data[$];
    logic [31:0]  q256_keep[$];
    logic         q256_last[$];
    logic [63:0]  q256_ts[$];
    logic         q256_ht[$];
    int empty_cnt64 = 0, err_cnt64 = 0, empty_cnt256 = 0, err_cnt256 = 0;

    always @(negedge clk) begin
        if (m_tvalid64 && m_tready64) begin
            q64_data.push_back(m_tdata64);
            q64_keep.push_back(m_tkeep64);
            q64_last.push_back(m_tlast64);
            q64_hdr.push_back(hdr64);
            q64_ts.push_back(ts64);
            q64_ht.push_back(ht64);
        end
        if (m_tvalid256 && m_tready256) begin
            q256_data.push_back(m_tdata256);
            q256_keep.push_back(m_tkeep256);
            q256_last.push_back(m_tlast256);
            q256_ts.push_back(ts256);
            q256_ht.push_back(ht256);
        end
        if (empty64)  empty_cnt64  <= empty_cnt64 + 1;
        if (err64)    err_cnt64    <= err_cnt64 + 1;
        if (empty256) empty_cnt256 <= empty_cnt256 + 1;
        if (err256)   err_cnt256   <= err_cnt256 + 1;
    end

    function automatic logic [63:0] make_hdr(input logic [2:0] ptype, input logic [4:0] nmd,
                                             input logic [15:0] len, input logic [15:0] seq);
        return {8'h00, ptype, nmd, seq, len, 16'h0000};
    endfunction

    // Drives one input beat and waits (bounded) for its handshake; called just after a posedge.
    task automatic send_beat(input bit wide, input logic [255:0] d, input logic last, input bit stall);
        bit hs = 1'b0;
        if (wide) begin
            s_tdata256 = d; s_tlast256 = last; s_tvalid256 = 1'b1;
        end else begin
            s_tdata64 = d[63:0]; s_tlast64 = last; s_tvalid64 = 1'b1;
        end
        for (int c = 0; c < 200 && !hs; c++) begin
            m_tready64  = stall ? ($urandom_range(0, 99) >= 60) : 1'b1;
            m_tready256 = 1'b1;
            @(negedge clk);
            hs = wide ? s_tready256 : s_tready64;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            tests_run++; fail_cnt++;
            $display("[TB] FAIL beat_timeout: handshake seen 0, required 1");
        end
    endtask

    task automatic idle(input int n);
        s_tvalid64 = 1'b0; s_tlast64 = 1'b0; s_tvalid256 = 1'b0; s_tlast256 = 1'b0;
        m_tready64 = 1'b1; m_tready256 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({m_tvalid64, hdr64, ts64, ht64, empty64, err64, s_tready64} !== {1'b0, 64'd0, 64'd0, 4'b0001}) begin
            fail_cnt++;
            $display("[TB] FAIL reset64: got v=%b h=%h t=%h ht=%b e=%b r=%b rdy=%b, required zeros with rdy=1",
                     m_tvalid64, hdr64, ts64, ht64, empty64, err64, s_tready64);
        end
        tests_run++;
        if ({m_tvalid256, hdr256, ts256, s_tready256} !== {1'b0, 128'd0, 1'b1}) begin
            fail_cnt++;
            $display("[TB] FAIL reset256: got v=%b h=%h t=%h rdy=%b, required 0/0/0/1",
                     m_tvalid256, hdr256, ts256, s_tready256);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_ts_mdata();
        logic [63:0] h, ts;
        logic [63:0] p[3];
        int base, e0, r0;
        h  = make_hdr(3'h7, 5'd2, 16'd56, 16'd1);
        ts = 64'h1122_3344_5566_7788;
        p  = '{64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0003};
        base = q64_data.size(); e0 = empty_cnt64; r0 = err_cnt64;
        send_beat(0, {192'd0, h}, 1'b0, 1'b0);
        send_beat(0, {192'd0, ts}, 1'b0, 1'b0);
        send_beat(0, {192'd0, 64'hDEAD_0000_0000_0000}, 1'b0, 1'b0);
        send_beat(0, {192'd0, 64'hDEAD_0000_0000_0001}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(0, {192'd0, p[i]}, (i == 2), 1'b0);
        idle(3);
        tests_run++;
        if (q64_data.size() - base !== 3) begin
            fail_cnt++;
            $display("[TB] FAIL ts_mdata_count: got %0d beats, required 3", q64_data.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            if (base + i < q64_data.size()) begin
                tests_run++;
                if ({q64_data[base+i], q64_keep[base+i], q64_last[base+i]} !== {p[i], 8'hFF, (i == 2)}) begin
                    fail_cnt++;
                    $display("[TB] FAIL ts_mdata_beat%0d: got %h/%h/%b, required %h/ff/%b",
                             i, q64_data[base+i], q64_keep[base+i], q64_last[base+i], p[i], (i == 2));
                end
                tests_run++;
                if ({q64_hdr[base+i], q64_ts[base+i], q64_ht[base+i]} !== {h, ts, 1'b1}) begin
                    fail_cnt++;
                    $display("[TB] FAIL ts_mdata_side%0d: got %h/%h/%b, required %h/%h/1",
                             i, q64_hdr[base+i], q64_ts[base+i], q64_ht[base+i], h, ts);
                end
            end
        end
        tests_run++;
        if ({empty_cnt64 - e0, err_cnt64 - r0} !== {32'd0, 32'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL ts_mdata_flags: got empty %0d err %0d, required 0 0", empty_cnt64 - e0, err_cnt64 - r0);
        end
    endtask

    task automatic test_wide_ts();
        logic [63:0] h;
        logic [255:0] p0, p1;
        int base, r0;
        h  = make_hdr(3'h7, 5'd0, 16'd72, 16'd2);
        p0 = {8{32'hC0DE_0001}};
        p1 = {8{32'hC0DE_0002}};
        base = q256_data.size(); r0 = err_cnt256;
        send_beat(1, {128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 64'd1234, h}, 1'b0, 1'b0);
        send_beat(1, p0, 1'b0, 1'b0);
        send_beat(1, p1, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if (q256_data.size() - base !== 2) begin
            fail_cnt++;
            $display("[TB] FAIL wide_count: got %0d beats, required 2", q256_data.size() - base);
        end else begin
            tests_run++;
            if ({q256_data[base], q256_keep[base], q256_last[base]} !== {p0, 32'hFFFF_FFFF, 1'b0}) begin
                fail_cnt++;
                $display("[TB] FAIL wide_beat0: got keep %h last %b, required ffffffff 0", q256_keep[base], q256_last[base]);
            end
            tests_run++;
            if ({q256_data[base+1], q256_keep[base+1], q256_last[base+1]} !== {p1, 32'h0000_00FF, 1'b1}) begin
                fail_cnt++;
                $display("[TB] FAIL wide_beat1: got keep %h last %b, required 000000ff 1", q256_keep[base+1], q256_last[base+1]);
            end
            tests_run++;
            if ({q256_ts[base+1], q256_ht[base+1]} !== {64'd1234, 1'b1}) begin
                fail_cnt++;
                $display("[TB] FAIL wide_side: got ts %0d ht %b, required 1234 1", q256_ts[base+1], q256_ht[base+1]);
            end
        end
        tests_run++;
        if (err_cnt256 - r0 !== 0) begin
            fail_cnt++;
            $display("[TB] FAIL wide_err: got %0d, required 0", err_cnt256 - r0);
        end
    endtask

    task automatic test_empty();
        logic [63:0] h;
        int base, e0, r0;
        h = make_hdr(3'h6, 5'd0, 16'd8, 16'd3);
        base = q64_data.size(); e0 = empty_cnt64; r0 = err_cnt64;
        send_beat(0, {192'd0, h}, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if ({q64_data.size() - base, empty_cnt64 - e0, err_cnt64 - r0} !== {32'd0, 32'd1, 32'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL empty_hdr: got beats %0d empty %0d err %0d, required 0 1 0",
                     q64_data.size() - base, empty_cnt64 - e0, err_cnt64 - r0);
        end
        tests_run++;
        if ({hdr64, ht64, ts64} !== {h, 1'b0, 64'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL empty_side: got hdr %h ht %b ts %h, required %h 0 0", hdr64, ht64, ts64, h);
        end
        // Length claims payload, but tlast lands on the only metadata word.
        h = make_hdr(3'h6, 5'd1, 16'd24, 16'd4);
        e0 = empty_cnt64; r0 = err_cnt64;
        send_beat(0, {192'd0, h}, 1'b0, 1'b0);
        send_beat(0, 256'd5, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if ({q64_data.size() - base, empty_cnt64 - e0, err_cnt64 - r0} !== {32'd0, 32'd1, 32'd1}) begin
            fail_cnt++;
            $display("[TB] FAIL empty_mdata: got beats %0d empty %0d err %0d, required 0 1 1",
                     q64_data.size() - base, empty_cnt64 - e0, err_cnt64 - r0);
        end
    endtask

    task automatic test_len_err();
        int base, r0;
        base = q64_data.size(); r0 = err_cnt64;
        send_beat(0, {192'd0, make_hdr(3'h6, 5'd0, 16'd40, 16'd5)}, 1'b0, 1'b0);
        send_beat(0, 256'h11, 1'b0, 1'b0);
        send_beat(0, 256'h22, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if ({q64_data.size() - base, err_cnt64 - r0} !== {32'd2, 32'd1}) begin
            fail_cnt++;
            $display("[TB] FAIL len_short: got beats %0d err %0d, required 2 1", q64_data.size() - base, err_cnt64 - r0);
        end
        // Follow-up packet: 20 bytes leaves 4 bytes on the last payload beat.
        base = q64_data.size(); r0 = err_cnt64;
        send_beat(0, {192'd0, make_hdr(3'h6, 5'd0, 16'd20, 16'd6)}, 1'b0, 1'b0);
        send_beat(0, 256'h33, 1'b0, 1'b0);
        send_beat(0, 256'h44, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if ({q64_data.size() - base, err_cnt64 - r0} !== {32'd2, 32'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL len_next: got beats %0d err %0d, required 2 0", q64_data.size() - base, err_cnt64 - r0);
        end else begin
            tests_run++;
            if ({q64_data[base+1], q64_keep[base+1], q64_last[base+1]} !== {64'h44, 8'h0F, 1'b1}) begin
                fail_cnt++;
                $display("[TB] FAIL len_keep: got %h/%h/%b, required 44/0f/1",
                         q64_data[base+1], q64_keep[base+1], q64_last[base+1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e_data[$], e_hdr[$], e_ts[$];
        logic [7:0]  e_keep[$];
        logic        e_last[$];
        logic [63:0] h, tsw, d;
        logic [2:0]  ptype;
        int nmd, pw, rem, hasts, base, e0, r0, n;
        base = q64_data.size(); e0 = empty_cnt64; r0 = err_cnt64;
        for (int k = 0; k < 100; k++) begin
            hasts = int'($urandom_range(0, 1));
            ptype = (hasts != 0) ? 3'h7 : 3'h6;
            nmd   = int'($urandom_range(0, 2));
            pw    = int'($urandom_range(1, 4));
            rem   = int'($urandom_range(1, 8));
            h     = make_hdr(ptype, 5'(nmd), 16'(8 * (1 + hasts + nmd) + 8 * (pw - 1) + rem), 16'(k));
            tsw   = {$urandom, $urandom};
            send_beat(0, {192'd0, h}, 1'b0, 1'b1);
            if (hasts != 0) send_beat(0, {192'd0, tsw}, 1'b0, 1'b1);
            for (int m = 0; m < nmd; m++) send_beat(0, {224'd0, $urandom}, 1'b0, 1'b1);
            for (int j = 0; j < pw; j++) begin
                d = {$urandom, $urandom};
                e_data.push_back(d);
                e_keep.push_back((j == pw - 1 && rem != 8) ? 8'((1 << rem) - 1) : 8'hFF);
                e_last.push_back(j == pw - 1);
                e_hdr.push_back(h);
                e_ts.push_back((hasts != 0) ? tsw : 64'd0);
                send_beat(0, {192'd0, d}, (j == pw - 1), 1'b1);
            end
        end
        idle(4);
        n = q64_data.size() - base;
        tests_run++;
        if (n !== e_data.size()) begin
            fail_cnt++;
            $display("[TB] FAIL b2b_count: got %0d beats, required %0d", n, e_data.size());
        end
        for (int i = 0; i < n && i < e_data.size(); i++) begin
            tests_run++;
            if ({q64_data[base+i], q64_keep[base+i], q64_last[base+i]} !== {e_data[i], e_keep[i], e_last[i]}) begin
                fail_cnt++;
                $display("[TB] FAIL b2b_beat%0d: got %h/%h/%b, required %h/%h/%b", i,
                         q64_data[base+i], q64_keep[base+i], q64_last[base+i], e_data[i], e_keep[i], e_last[i]);
            end
            tests_run++;
            if ({q64_hdr[base+i], q64_ts[base+i]} !== {e_hdr[i], e_ts[i]}) begin
                fail_cnt++;
                $display("[TB] FAIL b2b_side%0d: got %h/%h, required %h/%h", i,
                         q64_hdr[base+i], q64_ts[base+i], e_hdr[i], e_ts[i]);
            end
        end
        tests_run++;
        if ({empty_cnt64 - e0, err_cnt64 - r0} !== {32'd0, 32'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL b2b_flags: got empty %0d err %0d, required 0 0", empty_cnt64 - e0, err_cnt64 - r0);
        end
    endtask

    task automatic test_reset_mdata();
        logic [63:0] h;
        int base, r0;
        send_beat(0, {192'd0, make_hdr(3'h7, 5'd3, 16'd48, 16'd7)}, 1'b0, 1'b0);
        send_beat(0, 256'h1234, 1'b0, 1'b0);
        send_beat(0, 256'h99, 1'b0, 1'b0);
        rst = 1'b1;
        s_tvalid64 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({m_tvalid64, hdr64, ts64, ht64, empty64, err64, s_tready64} !== {1'b0, 64'd0, 64'd0, 4'b0001}) begin
            fail_cnt++;
            $display("[TB] FAIL rst_mdata: got v=%b h=%h t=%h ht=%b e=%b r=%b rdy=%b, required zeros with rdy=1",
                     m_tvalid64, hdr64, ts64, ht64, empty64, err64, s_tready64);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        h = make_hdr(3'h7, 5'd0, 16'd32, 16'd8);
        base = q64_data.size(); r0 = err_cnt64;
        send_beat(0, {192'd0, h}, 1'b0, 1'b0);
        send_beat(0, {192'd0, 64'h0BAD_F00D_0000_0042}, 1'b0, 1'b0);
        send_beat(0, 256'h55, 1'b0, 1'b0);
        send_beat(0, 256'h66, 1'b1, 1'b0);
        idle(3);
        tests_run++;
        if ({q64_data.size() - base, err_cnt64 - r0} !== {32'd2, 32'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL rst_next: got beats %0d err %0d, required 2 0", q64_data.size() - base, err_cnt64 - r0);
        end else begin
            tests_run++;
            if ({q64_data[base+1], q64_keep[base+1], q64_hdr[base+1], q64_ts[base+1]} !==
                {64'h66, 8'hFF, h, 64'h0BAD_F00D_0000_0042}) begin
                fail_cnt++;
                $display("[TB] FAIL rst_next_beat: got %h/%h/%h/%h, required 66/ff/%h/0badf00d00000042",
                         q64_data[base+1], q64_keep[base+1], q64_hdr[base+1], q64_ts[base+1], h);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_tdata64 = '0; s_tlast64 = 1'b0; s_tvalid64 = 1'b0; m_tready64 = 1'b1;
        s_tdata256 = '0; s_tlast256 = 1'b0; s_tvalid256 = 1'b0; m_tready256 = 1'b1;
        test_reset();
        test_ts_mdata();
        test_wide_ts();
        test_empty();
        test_len_err();
        test_back_to_back();
        test_reset_mdata();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
